i2c_reg_peripheral: RTL and testbench

Parametrised I2C target with an internal register bank, clocked from the FPGA system clock instead of SCL. SCL and SDA are oversampled, START, repeated-START and STOP are detected on any bit, and the target supports multi-byte register writes and reads with an address pointer. It sits between the board I2C pins, through an open-drain pad, and the fabric logic that consumes configuration registers and publishes status registers.

---
 rtl/i2c_reg_peripheral.sv | 256 +++++++++++++++++++++++++
 tb/tb_i2c_reg_peripheral.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_reg_peripheral.sv
// I2C target clocked from the system clock, with an NUM_REGS x 8-bit register bank and address pointer.
// Define I2C_AUTOINC_EN to advance the pointer after every written byte and every ACKed read byte.
module i2c_reg_peripheral #(
  parameter logic [6:0]  DEV_ADDR = 7'h42,
  parameter int unsigned NUM_REGS = 16,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  input  logic                  sda_in,
  output logic                  sda_oe,
  input  logic                  host_we,
  input  logic [ADDR_W-1:0]     host_addr,
  input  logic [7:0]            host_wdata,
  output logic [8*NUM_REGS-1:0] regs_flat,
  output logic                  i2c_wr_pulse,
  output logic [ADDR_W-1:0]     i2c_wr_addr,
  output logic                  busy
);

`ifdef I2C_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV_ADDR,
    ST_DEV_ACK,
    ST_REG_ADDR,
    ST_REG_ACK,
    ST_WRITE,
    ST_WRITE_ACK,
    ST_READ,
    ST_READ_ACK
  } state_t;

  state_t            state, state_n;
  logic [3:0]        cnt, cnt_n;
  logic [7:0]        shift, shift_n;
  logic [7:0]        tx, tx_n;
  logic [ADDR_W-1:0] ptr, ptr_n, ptr_wrap, ptr_inc;
  logic              sda_oe_n;
  logic              rw, rw_n;
  logic              mack, mack_n;
  logic              wr_en;
  logic [7:0]        rx_byte;
  logic              reg_ok;
  logic [7:0]        regs [NUM_REGS];

  // Synchronisers idle high so that releasing reset on an idle bus creates no edges
  logic [1:0] scl_sync, sda_sync;
  logic       scl_d, sda_d, scl_s, sda_s;
  logic       scl_rise, scl_fall, start_det, stop_det;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], scl};
      sda_sync <= {sda_sync[0], sda_in};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign scl_s     = scl_sync[1];
  assign sda_s     = sda_sync[1];
  assign scl_rise  = scl_s & ~scl_d;
  assign scl_fall  = ~scl_s & scl_d;
  assign start_det = scl_s & scl_d & sda_d & ~sda_s;
  assign stop_det  = scl_s & scl_d & ~sda_d & sda_s;

  assign rx_byte = {shift[6:0], sda_s};
  assign reg_ok  = {1'b0, shift} < 9'(NUM_REGS);
  assign busy    = (state != ST_IDLE) && (state != ST_DEV_ADDR);

  always_comb begin
    ptr_wrap = (ptr == ADDR_W'(NUM_REGS - 1)) ? '0 : ptr + ADDR_W'(1);
    ptr_inc  = AUTOINC ? ptr_wrap : ptr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      shift  <= '0;
      tx     <= '0;
      ptr    <= '0;
      sda_oe <= 1'b0;
      rw     <= 1'b0;
      mack   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      shift  <= shift_n;
      tx     <= tx_n;
      ptr    <= ptr_n;
      sda_oe <= sda_oe_n;
      rw     <= rw_n;
      mack   <= mack_n;
    end
  end

  // cnt counts sampled SCL rises in a byte; the fall after the 8th rise closes the byte
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    shift_n  = shift;
    tx_n     = tx;
    ptr_n    = ptr;
    sda_oe_n = sda_oe;
    rw_n     = rw;
    mack_n   = mack;
    wr_en    = 1'b0;

    unique case (state)
      ST_IDLE: begin
      end

      ST_DEV_ADDR, ST_REG_ADDR, ST_WRITE: begin
        if (scl_rise && cnt != 4'd8) begin
          shift_n = rx_byte;
          cnt_n   = cnt + 4'd1;
          if (state == ST_WRITE && cnt == 4'd7) begin
            wr_en = 1'b1;
            ptr_n = ptr_inc;
          end
        end else if (scl_fall && cnt == 4'd8) begin
          cnt_n = '0;
          if (state == ST_DEV_ADDR) begin
            if (shift[7:1] == DEV_ADDR) begin
              rw_n     = shift[0];
              state_n  = ST_DEV_ACK;
              sda_oe_n = 1'b1;
            end else begin
              state_n = ST_IDLE;
            end
          end else if (state == ST_REG_ADDR) begin
            if (reg_ok) begin
              ptr_n    = shift[ADDR_W-1:0];
              state_n  = ST_REG_ACK;
              sda_oe_n = 1'b1;
            end else begin
              state_n = ST_IDLE;
            end
          end else begin
            state_n  = ST_WRITE_ACK;
            sda_oe_n = 1'b1;
          end
        end
      end

      ST_DEV_ACK: begin
        if (scl_fall) begin
          cnt_n = '0;
          if (rw) begin
            state_n  = ST_READ;
            tx_n     = regs[ptr];
            sda_oe_n = ~regs[ptr][7];
          end else begin
            state_n  = ST_REG_ADDR;
            sda_oe_n = 1'b0;
          end
        end
      end

      ST_REG_ACK, ST_WRITE_ACK: begin
        if (scl_fall) begin
          cnt_n    = '0;
          state_n  = ST_WRITE;
          sda_oe_n = 1'b0;
        end
      end

      ST_READ: begin
        if (scl_rise && cnt != 4'd8) begin
          cnt_n = cnt + 4'd1;
        end else if (scl_fall && cnt != 4'd0) begin
          if (cnt == 4'd8) begin
            cnt_n    = '0;
            state_n  = ST_READ_ACK;
            sda_oe_n = 1'b0;
          end else begin
            tx_n     = {tx[6:0], 1'b0};
            sda_oe_n = ~tx[6];
          end
        end
      end

      ST_READ_ACK: begin
        if (scl_rise) begin
          mack_n = ~sda_s;
        end else if (scl_fall) begin
          cnt_n = '0;
          if (mack) begin
            ptr_n    = ptr_inc;
            tx_n     = regs[ptr_inc];
            sda_oe_n = ~regs[ptr_inc][7];
            state_n  = ST_READ;
          end else begin
            state_n  = ST_IDLE;
            sda_oe_n = 1'b0;
          end
        end
      end

      default: state_n = ST_IDLE;
    endcase

    if (start_det) begin
      state_n  = ST_DEV_ADDR;
      cnt_n    = '0;
      sda_oe_n = 1'b0;
      wr_en    = 1'b0;
      ptr_n    = ptr;
    end else if (stop_det) begin
      state_n  = ST_IDLE;
      cnt_n    = '0;
      sda_oe_n = 1'b0;
      wr_en    = 1'b0;
      ptr_n    = ptr;
    end
  end

  // I2C write is issued after the host write so it wins on an address collision
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      if (host_we) regs[host_addr] <= host_wdata;
      if (wr_en)   regs[ptr]       <= rx_byte;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i2c_wr_pulse <= 1'b0;
      i2c_wr_addr  <= '0;
    end else begin
      i2c_wr_pulse <= wr_en;
      if (wr_en) i2c_wr_addr <= ptr;
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) regs_flat[8*i +: 8] = regs[i];
  end

endmodule

// File: tb/tb_i2c_reg_peripheral.sv
// Randomised bench for i2c_reg_peripheral: bus-level I2C master, register-bank reference model,
// and a monitor that scores write pulses and read bytes against expectation queues.
`timescale 1ns/1ps
module tb_i2c_reg_peripheral;
  localparam logic [6:0] DEV = 7'h42;
  localparam int NR = 16;
  localparam int AW = 4;
  localparam int Q  = 5;
`ifdef I2C_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          scl = 1'b1;
  logic          sda_m = 1'b1;
  logic          sda_line;
  logic          sda_oe;
  logic          host_we = 1'b0;
  logic [AW-1:0] host_addr = '0;
  logic [7:0]    host_wdata = '0;
  logic [8*NR-1:0] regs_flat;
  logic          i2c_wr_pulse;
  logic [AW-1:0] i2c_wr_addr;
  logic          busy;

  assign sda_line = sda_m & ~sda_oe;

  i2c_reg_peripheral #(.DEV_ADDR(DEV), .NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_line), .sda_oe(sda_oe),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .regs_flat(regs_flat), .i2c_wr_pulse(i2c_wr_pulse), .i2c_wr_addr(i2c_wr_addr),
    .busy(busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [7:0]  m_regs [NR];
  int          m_ptr = 0;
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  logic [7:0]  obs_rd [$];
  logic        oe_seen = 1'b0;
  logic [15:0] mon_e;
  logic [7:0]  mon_o;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sda_oe) oe_seen = 1'b1;
    if (i2c_wr_pulse) begin
      if (exp_wr.size() == 0) begin
        chk("wr_pulse_pending", int'(exp_wr.size() != 0), 1);
      end else begin
        mon_e = exp_wr.pop_front();
        chk("wr_addr", int'(i2c_wr_addr), int'(mon_e[15:8]));
        chk("wr_data", int'(regs_flat[8*int'(mon_e[15:8]) +: 8]), int'(mon_e[7:0]));
      end
    end
    if (obs_rd.size() != 0) begin
      mon_o = obs_rd.pop_front();
      if (exp_rd.size() == 0) chk("rd_byte_pending", int'(exp_rd.size() != 0), 1);
      else chk("rd_byte", int'(mon_o), int'(exp_rd.pop_front()));
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    tick(Q); sda_m = b; tick(Q); scl = 1'b1; tick(2*Q); scl = 1'b0;
  endtask

  task automatic recv_bit(output logic b);
    tick(Q); sda_m = 1'b1; tick(Q); scl = 1'b1; tick(Q); b = sda_line; tick(Q); scl = 1'b0;
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      tick(Q); sda_m = 1'b1; tick(Q); scl = 1'b1;
    end
    tick(Q); sda_m = 1'b0; tick(Q); scl = 1'b0;
  endtask

  task automatic bus_stop();
    tick(Q); sda_m = 1'b0; tick(Q); scl = 1'b1; tick(Q); sda_m = 1'b1; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] b, output logic ack);
    logic a;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    recv_bit(a);
    ack = ~a;
  endtask

  task automatic read_byte(input logic ack);
    logic [7:0] v;
    for (int i = 7; i >= 0; i--) recv_bit(v[i]);
    obs_rd.push_back(v);
    send_bit(~ack);
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk); host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk); host_we = 1'b0;
    m_regs[a] = d;
  endtask

  task automatic check_bank();
    for (int i = 0; i < NR; i++)
      chk($sformatf("regs[%0d]", i), int'(regs_flat[8*i +: 8]), int'(m_regs[i]));
  endtask

  task automatic wr_txn(input logic [6:0] dev, input logic [7:0] ra, input int n,
                        input bit keep, output bit ok);
    logic a;
    logic [7:0] d;
    bit dev_ok, reg_ok;
    dev_ok = (dev == DEV);
    reg_ok = (int'(ra) < NR);
    ok = 1'b0;
    bus_start();
    write_byte({dev, 1'b0}, a);
    chk("dev_ack", int'(a), int'(dev_ok));
    chk("busy_after_dev", int'(busy), int'(dev_ok));
    if (!dev_ok) begin bus_stop(); return; end
    write_byte(ra, a);
    chk("reg_ack", int'(a), int'(reg_ok));
    chk("busy_after_reg", int'(busy), int'(reg_ok));
    if (!reg_ok) begin bus_stop(); return; end
    m_ptr = int'(ra);
    for (int k = 0; k < n; k++) begin
      d = 8'($urandom);
      m_regs[m_ptr] = d;
      exp_wr.push_back({8'(m_ptr), d});
      if (AUTOINC) m_ptr = (m_ptr + 1) % NR;
      write_byte(d, a);
      chk("data_ack", int'(a), 1);
    end
    ok = 1'b1;
    if (!keep) bus_stop();
  endtask

  task automatic rd_txn(input logic [6:0] dev, input int n);
    logic a;
    bit ack;
    bus_start();
    write_byte({dev, 1'b1}, a);
    chk("rd_dev_ack", int'(a), int'(dev == DEV));
    if (dev == DEV) begin
      for (int k = 0; k < n; k++) begin
        ack = (k < n - 1);
        exp_rd.push_back(m_regs[m_ptr]);
        if (ack && AUTOINC) m_ptr = (m_ptr + 1) % NR;
        read_byte(ack);
      end
    end
    bus_stop();
    tick(4);
    chk("busy_after_rd", int'(busy), 0);
  endtask

  initial begin
    bit ok;
    logic a;
    logic [6:0] dev;
    logic [7:0] ra;
    int guard, mode;

    for (int i = 0; i < NR; i++) m_regs[i] = '0;

    tick(3);
    chk("rst_sda_oe", int'(sda_oe), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr_pulse", int'(i2c_wr_pulse), 0);
    chk("rst_wr_addr", int'(i2c_wr_addr), 0);
    check_bank();
    rst = 1'b0;
    tick(4);

    // Two-byte write at register 3
    exp_wr.push_back(16'h03A5);
    m_regs[3] = 8'hA5;
    m_ptr = AUTOINC ? 4 : 3;
    exp_wr.push_back({8'(m_ptr), 8'h5A});
    m_regs[m_ptr] = 8'h5A;
    bus_start();
    write_byte({DEV, 1'b0}, a); chk("t1_dev_ack", int'(a), 1);
    write_byte(8'h03, a);       chk("t1_reg_ack", int'(a), 1);
    write_byte(8'hA5, a);       chk("t1_d0_ack", int'(a), 1);
    write_byte(8'h5A, a);       chk("t1_d1_ack", int'(a), 1);
    if (AUTOINC) m_ptr = 5;
    bus_stop();
    tick(4);
    check_bank();

    // Pointer write, repeated START, two-byte read across the wrap point
    host_write(4'hF, 8'h66);
    host_write(4'h0, 8'h11);
    wr_txn(DEV, 8'h0F, 0, 1'b1, ok);
    rd_txn(DEV, 2);

    // Foreign address: no drive, no busy
    oe_seen = 1'b0;
    wr_txn(7'h43, 8'h03, 1, 1'b0, ok);
    tick(4);
    chk("bad_addr_oe_seen", int'(oe_seen), 0);
    check_bank();

    // Out-of-range register byte
    wr_txn(DEV, 8'h10, 1, 1'b0, ok);
    tick(4);
    chk("bad_reg_busy", int'(busy), 0);
    check_bank();

    // STOP after four data bits
    wr_txn(DEV, 8'h05, 0, 1'b1, ok);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom_range(0, 1)));
    bus_stop();
    tick(4);
    chk("stop_mid_oe", int'(sda_oe), 0);
    chk("stop_mid_busy", int'(busy), 0);
    check_bank();

    // Reset while driving a read bit low
    host_write(4'h7, 8'h3C);
    wr_txn(DEV, 8'h07, 0, 1'b1, ok);
    bus_start();
    write_byte({DEV, 1'b1}, a);
    chk("rst_rd_dev_ack", int'(a), 1);
    tick(Q);
    guard = 0;
    while (!sda_oe && guard < 20) begin tick(1); guard++; end
    chk("rst_rd_oe_before", int'(sda_oe), 1);
    rst = 1'b1;
    #1;
    chk("rst_oe_async", int'(sda_oe), 0);
    tick(2);
    chk("rst_mid_busy", int'(busy), 0);
    for (int i = 0; i < NR; i++) m_regs[i] = '0;
    m_ptr = 0;
    check_bank();
    scl = 1'b1; sda_m = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(4);
    wr_txn(DEV, 8'h02, 2, 1'b0, ok);
    chk("post_rst_ok", int'(ok), 1);
    wr_txn(DEV, 8'h02, 0, 1'b1, ok);
    rd_txn(DEV, 2);
    check_bank();

    // Randomised traffic
    for (int it = 0; it < 12; it++) begin
      if ($urandom_range(0, 1) == 1) host_write(AW'($urandom_range(0, NR - 1)), 8'($urandom));
      dev  = ($urandom_range(0, 7) == 0) ? (DEV ^ 7'(7'd1 << $urandom_range(0, 6))) : DEV;
      ra   = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(NR, 255)) : 8'($urandom_range(0, NR - 1));
      mode = $urandom_range(0, 2);
      if (mode == 0) begin
        wr_txn(dev, ra, $urandom_range(1, 3), 1'b0, ok);
      end else if (mode == 1) begin
        wr_txn(dev, ra, 0, 1'b1, ok);
        if (ok) rd_txn(DEV, $urandom_range(1, 4));
      end else begin
        rd_txn(dev, $urandom_range(1, 3));
      end
      tick(4);
      check_bank();
    end

    tick(10);
    chk("wr_queue_drained", exp_wr.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
